apb_master: RTL and testbench

Bridge from the CPU's simple load/store request port to the on-chip APB peripheral bus. It captures one CPU request, decodes the address to one of `NUM_SLAVES` peripheral slots, and runs the APB SETUP/ACCESS sequence. It waits for the selected slave's `PREADY`, then returns read data and a one-cycle completion pulse to the CPU. It sits directly upstream of every APB slave, including the data RAM and the GPIO/UART peripherals.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_master_if.sv | 30 +++
 rtl/apb_decoder.sv | 28 ++
 rtl/apb_master.sv | 175 +++++++++++++++++
 tb/tb_apb_master.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the CPU-to-APB bridge: FSM states, slot width
// and the address fields used for peripheral decode.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int          APB_SLOT_W      = 4;
    localparam logic [31:0] APB_PERIPH_BASE = 32'h1000_0000;

    localparam int SLOT_LSB   = 12;
    localparam int SLOT_MSB   = 15;
    localparam int REGION_LSB = 16;
    localparam int REGION_MSB = 31;

    function automatic logic [APB_SLOT_W-1:0] addr_slot(input logic [31:0] a);
        return a[SLOT_MSB:SLOT_LSB];
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// CPU request port plus APB bus bundle; the bridge uses the master modport,
// the CPU/slave side (or a bench) uses the slave modport.
interface apb_master_if #(
    parameter int NUM_SLAVES = 5
);
    logic                       transfer;
    logic                       write;
    logic [31:0]                addr;
    logic [31:0]                wdata;
    logic [31:0]                rdata;
    logic                       ready;
    logic                       err;
    logic [31:0]                PADDR;
    logic                       PWRITE;
    logic                       PENABLE;
    logic [31:0]                PWDATA;
    logic [NUM_SLAVES-1:0]      PSEL;
    logic [NUM_SLAVES*32-1:0]   PRDATA;
    logic [NUM_SLAVES-1:0]      PREADY;

    modport master (
        input  transfer, write, addr, wdata, PRDATA, PREADY,
        output rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
    );

    modport slave (
        output transfer, write, addr, wdata, PRDATA, PREADY,
        input  rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
    );
endinterface

// File: rtl/apb_decoder.sv
// Combinational peripheral decoder: region match on addr[31:16], slot from
// addr[15:12], one-hot select for slots that exist.
module apb_decoder
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES = 5,
    parameter logic [31:0] BASE_ADDR  = APB_PERIPH_BASE
) (
    input  logic [31:0]            addr,
    output logic                   hit,
    output logic [APB_SLOT_W-1:0]  slot,
    output logic [NUM_SLAVES-1:0]  sel
);
    logic region_match;
    logic unused_low_bits;

    assign slot            = addr_slot(addr);
    assign region_match    = (addr[REGION_MSB:REGION_LSB] == BASE_ADDR[REGION_MSB:REGION_LSB]);
    assign hit             = region_match && (int'(slot) < NUM_SLAVES);
    assign unused_low_bits = ^addr[SLOT_LSB-1:0];

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel[gi] = hit && (slot == APB_SLOT_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// CPU-to-APB bridge: captures one request, decodes it to a slot and runs
// SETUP/ACCESS. Optional ACCESS-phase timeout when APB_TIMEOUT_EN is defined.
module apb_master
    import apb_pkg::*;
#(
    parameter int          NUM_SLAVES     = 5,
    parameter logic [31:0] BASE_ADDR      = APB_PERIPH_BASE,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_master_if.master  bus
);
    apb_state_t                 state_reg, state_next;
    logic                       pending_reg, pending_next;
    logic                       hit_reg, hit_next;
    logic [APB_SLOT_W-1:0]      slot_reg, slot_next;
    logic [NUM_SLAVES-1:0]      sel_reg, sel_next;
    logic [31:0]                paddr_reg, paddr_next;
    logic [31:0]                pwdata_reg, pwdata_next;
    logic                       pwrite_reg, pwrite_next;
    logic [31:0]                rdata_reg, rdata_next;
    logic                       ready_reg, ready_next;
    logic                       err_reg, err_next;

    logic                       dec_hit;
    logic [APB_SLOT_W-1:0]      dec_slot;
    logic [NUM_SLAVES-1:0]      dec_sel;
    logic                       sel_pready;
    logic [31:0]                sel_prdata;
    logic [NUM_SLAVES-1:0][31:0] slot_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]           tmo_cnt_reg, tmo_cnt_next;
    logic                       tmo_hit;
    assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    apb_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR)
    ) u_decoder (
        .addr (bus.addr),
        .hit  (dec_hit),
        .slot (dec_slot),
        .sel  (dec_sel)
    );

    // Only the captured slot may complete the transfer or supply read data.
    assign sel_pready = |(bus.PREADY & sel_reg);

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdata
            assign slot_rdata[gi] = (slot_reg == APB_SLOT_W'(gi)) ? bus.PRDATA[32*gi +: 32] : 32'd0;
        end
    endgenerate

    always_comb begin
        sel_prdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_prdata = sel_prdata | slot_rdata[i];
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = 1'b0;
        hit_next     = hit_reg;
        slot_next    = slot_reg;
        sel_next     = sel_reg;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;
        pwrite_next  = pwrite_reg;
        rdata_next   = rdata_reg;
        ready_next   = 1'b0;
        err_next     = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_next = tmo_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                // A capture takes one cycle; the decode result then picks
                // between starting the bus cycle and an immediate error.
                if (pending_reg) begin
                    if (hit_reg) begin
                        state_next = SETUP;
                    end else begin
                        ready_next = 1'b1;
                        err_next   = 1'b1;
                        rdata_next = 32'd0;
                    end
                end else if (bus.transfer) begin
                    pending_next = 1'b1;
                    hit_next     = dec_hit;
                    slot_next    = dec_slot;
                    sel_next     = dec_sel;
                    paddr_next   = bus.addr;
                    pwdata_next  = bus.wdata;
                    pwrite_next  = bus.write;
                end
            end
            SETUP: begin
                state_next = ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_next = '0;
`endif
            end
            ACCESS: begin
                if (sel_pready) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    rdata_next = pwrite_reg ? 32'd0 : sel_prdata;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    err_next   = 1'b1;
                    rdata_next = 32'd0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg   <= IDLE;
            pending_reg <= 1'b0;
            hit_reg     <= 1'b0;
            slot_reg    <= '0;
            sel_reg     <= '0;
            paddr_reg   <= 32'd0;
            pwdata_reg  <= 32'd0;
            pwrite_reg  <= 1'b0;
            rdata_reg   <= 32'd0;
            ready_reg   <= 1'b0;
            err_reg     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            hit_reg     <= hit_next;
            slot_reg    <= slot_next;
            sel_reg     <= sel_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            pwrite_reg  <= pwrite_next;
            rdata_reg   <= rdata_next;
            ready_reg   <= ready_next;
            err_reg     <= err_next;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_reg <= tmo_cnt_next;
`endif
        end
    end

    assign bus.PSEL    = (state_reg != IDLE) ? sel_reg : '0;
    assign bus.PENABLE = (state_reg == ACCESS);
    assign bus.PADDR   = paddr_reg;
    assign bus.PWDATA  = pwdata_reg;
    assign bus.PWRITE  = pwrite_reg;
    assign bus.rdata   = rdata_reg;
    assign bus.ready   = ready_reg;
    assign bus.err     = err_reg;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed cases plus randomized transfers
// compared every cycle against a transaction-timeline model.
`timescale 1ns/1ps
module tb_apb_master;
    localparam int NS = 5;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    always #5 PCLK = ~PCLK;

    apb_master_if #(.NUM_SLAVES(NS)) bus ();

    apb_master #(
        .NUM_SLAVES     (NS),
        .BASE_ADDR      (32'h1000_0000),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Model of the transaction in flight / last transaction.
    bit          chk_en = 0;
    bit          tr_valid = 0;
    int          tr_c0, tr_done, tr_slot;
    bit          tr_hit, tr_err;
    logic [31:0] tr_rdata;
    logic [31:0] exp_paddr = 0, exp_pwdata = 0;
    logic        exp_pwrite = 0;

    // Observations for the literal pins.
    int          obs_ready_k;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic [NS-1:0] obs_psel_k1;
    logic        obs_pen_k2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    logic [NS-1:0] e_psel;
    logic          e_pen, e_rdy, e_err;
    logic [31:0]   e_rdata;
    int            k;

    always @(negedge PCLK) begin
        if (chk_en) begin
            e_psel = '0; e_pen = 1'b0; e_rdy = 1'b0; e_err = 1'b0; e_rdata = 32'd0; k = -1;
            if (tr_valid) begin
                k = cyc - tr_c0;
                if (tr_hit && k >= 1 && k < tr_done) e_psel = NS'(1) << tr_slot;
                if (tr_hit && k >= 2 && k < tr_done) e_pen = 1'b1;
                if (k == tr_done) begin
                    e_rdy = 1'b1; e_err = tr_err; e_rdata = tr_rdata;
                end
            end
            check("PSEL", 64'(bus.PSEL), 64'(e_psel));
            check("PENABLE", 64'(bus.PENABLE), 64'(e_pen));
            check("ready", 64'(bus.ready), 64'(e_rdy));
            check("err", 64'(bus.err), 64'(e_err));
            check("PADDR", 64'(bus.PADDR), 64'(exp_paddr));
            check("PWDATA", 64'(bus.PWDATA), 64'(exp_pwdata));
            check("PWRITE", 64'(bus.PWRITE), 64'(exp_pwrite));
            if (e_rdy || !tr_valid) check("rdata", 64'(bus.rdata), 64'(e_rdata));
            if (bus.ready === 1'b1) begin
                obs_ready_k = k; obs_rdata = bus.rdata; obs_err = bus.err;
            end
            if (tr_valid && k == 1) obs_psel_k1 = bus.PSEL;
            if (tr_valid && k == 2) obs_pen_k2 = bus.PENABLE;
        end
    end

    task automatic drive_slaves(input int kk, input bit m_hit, input int slot, input int w,
                                input logic [31:0] rdv, input bit pin0);
        for (int s = 0; s < NS; s++) begin
            if (kk >= 0 && m_hit && s == slot) begin
                bus.PRDATA[32*s +: 32] = rdv;
                if (kk < 2) bus.PREADY[s] = 1'($urandom_range(0, 1));
                else        bus.PREADY[s] = (kk >= 2 + w);
            end else if (pin0 && s == 0) begin
                bus.PREADY[s] = 1'b1;
                bus.PRDATA[32*s +: 32] = 32'hFFFF_FFFF;
            end else begin
                bus.PREADY[s] = 1'($urandom_range(0, 1));
                bus.PRDATA[32*s +: 32] = $urandom;
            end
        end
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                            input int w, input bit pin0, input int rst_k, input bit spur,
                            input logic [31:0] rdv);
        bit m_hit;
        int slot;
        m_hit = ((a >> 16) == 32'h1000) && (((a >> 12) & 32'hF) < NS);
        slot  = int'((a >> 12) & 32'hF);
        obs_ready_k = -1; obs_psel_k1 = '0; obs_pen_k2 = 1'b0; obs_rdata = 32'hDEAD_BEEF; obs_err = 1'bx;
        bus.transfer = 1'b1; bus.addr = a; bus.write = wr; bus.wdata = wd;
        drive_slaves(-1, m_hit, slot, w, rdv, pin0);
        tick();
        tr_valid = 1; tr_c0 = cyc; tr_hit = m_hit; tr_slot = slot;
        exp_paddr = a; exp_pwdata = wd; exp_pwrite = wr;
        tr_done = 3 + w; tr_err = 0;
`ifdef APB_TIMEOUT_EN
        if (w >= TO) begin tr_done = 2 + TO; tr_err = 1; end
`endif
        if (!m_hit) begin tr_done = 1; tr_err = 1; end
        tr_rdata = (tr_err || wr) ? 32'd0 : rdv;
        for (int kk = 0; kk <= tr_done; kk++) begin
            if (kk == rst_k) begin
                PRESET = 1'b1; bus.transfer = 1'b0;
                tick();
                PRESET = 1'b0;
                tr_valid = 0; exp_paddr = 0; exp_pwdata = 0; exp_pwrite = 0;
                tick();
                return;
            end
            if (spur && kk < tr_done) begin
                bus.transfer = 1'($urandom_range(0, 1));
                bus.addr = $urandom; bus.wdata = $urandom; bus.write = 1'($urandom_range(0, 1));
            end else begin
                bus.transfer = 1'b0;
            end
            drive_slaves(kk, m_hit, slot, w, rdv, pin0);
            tick();
        end
        bus.transfer = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bus.transfer = 0; bus.write = 0; bus.addr = 0; bus.wdata = 0;
        bus.PREADY = '0; bus.PRDATA = '0;
        PRESET = 1'b1;
        tick();
        chk_en = 1;
        tick();
        PRESET = 1'b0;
        tick();

        // Zero-wait write to slot 3.
        run_xfer(32'h1000_3010, 1'b1, 32'hA5A5_0001, 0, 0, -1, 0, 32'h0);
        check("zw_ready_cycle", 64'(obs_ready_k), 64'(3));
        check("zw_psel_c1", 64'(obs_psel_k1), 64'(5'b01000));
        check("zw_penable_c2", 64'(obs_pen_k2), 64'(1));
        check("zw_err", 64'(obs_err), 64'(0));

        // Registered-ready read: one wait state.
        run_xfer(32'h1000_3010, 1'b0, 32'h0, 1, 0, -1, 0, 32'hA5A5_0001);
        check("rr_ready_cycle", 64'(obs_ready_k), 64'(4));
        check("rr_rdata", 64'(obs_rdata), 64'(32'hA5A5_0001));

        // Decode misses: outside region, and slot beyond NUM_SLAVES.
        run_xfer(32'h2000_0000, 1'b0, 32'h0, 0, 0, -1, 1, 32'h1111_1111);
        check("miss_region_cycle", 64'(obs_ready_k), 64'(1));
        check("miss_region_err", 64'(obs_err), 64'(1));
        check("miss_region_rdata", 64'(obs_rdata), 64'(0));
        run_xfer(32'h1000_7000, 1'b0, 32'h0, 0, 0, -1, 0, 32'h2222_2222);
        check("miss_slot_cycle", 64'(obs_ready_k), 64'(1));
        check("miss_slot_err", 64'(obs_err), 64'(1));

        // Slot 1 waits 5 ACCESS cycles while slot 0 shouts ready; stray transfers ignored.
        run_xfer(32'h1000_1020, 1'b0, 32'h0, 5, 1, -1, 1, 32'h1234_5678);
        check("dis_ready_cycle", 64'(obs_ready_k), 64'(8));
        check("dis_rdata", 64'(obs_rdata), 64'(32'h1234_5678));

`ifdef APB_TIMEOUT_EN
        run_xfer(32'h1000_2004, 1'b0, 32'h0, 1000, 0, -1, 0, 32'h3333_3333);
        check("tmo_ready_cycle", 64'(obs_ready_k), 64'(18));
        check("tmo_err", 64'(obs_err), 64'(1));
        check("tmo_rdata", 64'(obs_rdata), 64'(0));
`endif
        // Ready on the 16th ACCESS cycle completes normally in either build.
        run_xfer(32'h1000_2004, 1'b0, 32'h0, 15, 0, -1, 0, 32'h4444_4444);
        check("late_ready_cycle", 64'(obs_ready_k), 64'(18));
        check("late_err", 64'(obs_err), 64'(0));
        check("late_rdata", 64'(obs_rdata), 64'(32'h4444_4444));

        // Reset during slot 4 wait, then a normal transfer.
        run_xfer(32'h1000_4008, 1'b0, 32'h0, 20, 0, 6, 0, 32'h5555_5555);
        check("rst_no_ready", 64'(obs_ready_k), 64'(-1));
        run_xfer(32'h1000_4008, 1'b0, 32'h0, 0, 0, -1, 0, 32'h6666_6666);
        check("post_rst_cycle", 64'(obs_ready_k), 64'(3));
        check("post_rst_rdata", 64'(obs_rdata), 64'(32'h6666_6666));

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:16] = 16'h1000;
            a[15:12] = 4'($urandom_range(0, 7));
            run_xfer(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 4)), 0,
                     (n % 15 == 7) ? 3 : -1, 1'($urandom_range(0, 1)), $urandom);
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
